secret_gen: RTL
===============

Name: secret_gen

Overview:
- Upstream stage of the 1A2B result checker.
- Builds the 4-digit secret: four distinct decimal digits (0–9), packed as 16 bits of 4-bit BCD.
- Digits are drawn by rejection sampling from a free-running 4-bit LFSR nibble stream (rnd). Nibbles >9 and repeated digits are rejected.
- A bounded-draw fallback guarantees termination. The packed secret feeds the checker's 16-bit random-digits input.

Parameters:
- MAX_DRAWS, 64: maximum DRAW-state cycles before switching to deterministic fill.
- CNT_W, 7: width of the draw counter; must satisfy 2^CNT_W > MAX_DRAWS.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a new secret; sampled every cycle.
- rnd  input  4  candidate nibble, valid every cycle (LFSR output).
- secret  output  16  packed digits; first accepted digit in [15:12], last in [3:0].
- busy  output  1  high in DRAW or FILL.
- done  output  1  high in DONE; secret is stable and valid.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; secret=16'h0000; used mask (10 bits)=0; digit count=0; draw counter=0; busy=0; done=0.
  - Reset has priority over start. Reset during any state aborts immediately.
- All outputs are registered or decoded directly from state registers. There is no combinational path from rnd or start to any output.
- States: IDLE, DRAW, FILL, DONE. busy = (DRAW|FILL). done = (state==DONE).
- start=1 in any state at a posedge, including DRAW/FILL (restart):
  - next state=DRAW; secret=0; used=0; count=0; draws=0.
  - start held high keeps re-clearing, so the block remains in DRAW with count 0.
- IDLE, start=0: hold.
- DRAW (start=0), each cycle:
  - draws increments.
  - If rnd<=9 and used[rnd]==0: secret <= {secret[11:0], rnd}; used[rnd] <= 1; count <= count+1.
  - Otherwise (rnd>=10 or duplicate) the nibble is dropped, and secret/used/count hold.
  - If the accept takes count to 4: next state=DONE.
  - Else if draws==MAX_DRAWS-1: next state=FILL. Digits already accepted are kept.
- FILL (start=0), each cycle:
  - Append the smallest digit d with used[d]==0; set used[d]; count++.
  - On count reaching 4: next state=DONE.
  - FILL never takes more than 4 cycles.
- DONE: secret, busy, done hold until start or reset. rnd is ignored.
- Latency:
  - start sampled at edge k; the first draw is sampled at edge k+1.
  - Best case: done=1 after edge k+4.
  - Worst case: after edge k+MAX_DRAWS+4.
- Width rules:
  - count is 3 bits and saturates in meaning at 4; 4 is a terminal value, not a wrap.
  - The draw counter never wraps within one run, because exit occurs at MAX_DRAWS-1.
- Simultaneous events:
  - Acceptance of the 4th digit on the cycle draws==MAX_DRAWS-1: DONE wins over FILL.
  - start and a pending 4th accept: start wins (restart).

Decomposition:
- Shared package (game_pkg):
  - state encoding constants IDLE=0, DRAW=1, FILL=2, DONE=3;
  - NUM_DIGITS=4;
  - DIGIT_MAX=9;
  - default MAX_DRAWS.
  - The checker and top-level reuse NUM_DIGITS and DIGIT_MAX.
- One sub-module, digit_pick:
  - combinational priority encoder, used[9:0] -> smallest unused digit (4 bits) plus valid.
  - Used by FILL; unit-testable standalone.

Test Plan:
- Normal draw: pulse start; rnd sequence 3,3,12,7,0,9 (one per cycle) -> duplicate 3 and 12 rejected; secret=16'h3709; done rises after the 6th draw edge; busy high for exactly 6 cycles.
- Fill fallback: MAX_DRAWS=8; rnd held at 5 -> 5 accepted, 7 rejects, then FILL appends 0,1,2; secret=16'h5012; done after edge k+11.
- Restart mid-draw: after accepting 4,8, assert start for one cycle, then feed 1,2,3,6 -> secret=16'h1236, with no trace of 4 or 8 in secret or used.
- Reset mid-operation: rst_n=0 for one cycle while in FILL -> next cycle secret=0, busy=0, done=0, state IDLE; rnd changes are ignored until start.
- DONE hold and simultaneity: after secret=16'h9876, toggle rnd freely for 20 cycles -> secret and done unchanged. Then start coinciding with a valid rnd -> restart wins, secret=0 next cycle.
- Start held high: start=1 for 10 cycles with valid rnd -> count stays 0, busy=1, done=0. Release -> normal 4-draw completion.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants for the 1A2B secret generator and checker
package game_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int NUM_DIGITS        = 4;
  localparam int DIGIT_MAX         = 9;
  localparam int DEFAULT_MAX_DRAWS = 64;

endpackage

// File: rtl/digit_pick.sv
// rtl/digit_pick.sv - priority encoder returning the smallest unused decimal digit
module digit_pick
  import game_pkg::*;
(
  input  logic [9:0] used,
  output logic [3:0] digit,
  output logic       valid
);

  // Scan from the top down so the lowest free digit is the last assignment and wins.
  always_comb begin
    digit = '0;
    valid = 1'b0;
    for (int i = DIGIT_MAX; i >= 0; i--) begin
      if (!used[i]) begin
        digit = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secret_gen.sv
// rtl/secret_gen.sv - builds four distinct BCD digits from an LFSR nibble stream
module secret_gen
  import game_pkg::*;
#(
  parameter int MAX_DRAWS = DEFAULT_MAX_DRAWS,
  parameter int CNT_W     = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  rnd,
  output logic [15:0] secret,
  output logic        busy,
  output logic        done
);

  state_t           state;
  logic [9:0]       used;
  logic [2:0]       count;
  logic [CNT_W-1:0] draws;

  logic [15:0]      used_ext;
  logic [9:0]       rnd_hot;
  logic [9:0]       pick_hot;
  logic             rnd_ok;
  logic [2:0]       count_inc;
  logic             last_draw;
  logic [3:0]       pick_digit;
  logic             pick_valid;

  digit_pick u_pick (
    .used  (used),
    .digit (pick_digit),
    .valid (pick_valid)
  );

  // Nibbles 10..15 are treated as permanently used, so one lookup rejects both
  // out-of-range and duplicate candidates.
  always_comb begin
    used_ext  = {6'h3f, used};
    rnd_ok    = ~used_ext[rnd];
    count_inc = count + 3'd1;
    last_draw = (draws == CNT_W'(MAX_DRAWS - 1));
    for (int i = 0; i <= DIGIT_MAX; i++) begin
      rnd_hot[i]  = (rnd == 4'(i));
      pick_hot[i] = (pick_digit == 4'(i));
    end
  end

  // Sequencer: restart on start, rejection-sample in DRAW, deterministic top-up in FILL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      secret <= '0;
      used   <= '0;
      count  <= '0;
      draws  <= '0;
    end else if (start) begin
      state  <= DRAW;
      secret <= '0;
      used   <= '0;
      count  <= '0;
      draws  <= '0;
    end else begin
      case (state)
        DRAW: begin
          draws <= draws + CNT_W'(1);
          if (rnd_ok) begin
            secret <= {secret[11:0], rnd};
            used   <= used | rnd_hot;
            count  <= count_inc;
          end
          // A fourth accept on the final draw still finishes normally.
          if (rnd_ok && (count_inc == 3'(NUM_DIGITS))) begin
            state <= DONE;
          end else if (last_draw) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (pick_valid) begin
            secret <= {secret[11:0], pick_digit};
            used   <= used | pick_hot;
            count  <= count_inc;
            if (count_inc == 3'(NUM_DIGITS)) begin
              state <= DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == DRAW) || (state == FILL);
  assign done = (state == DONE);

endmodule
